// File: rtl/veri5_eth_arb_pkg.sv
// rtl/veri5_eth_arb_pkg.sv - shared types and constants for the veri5 eth packet arbiters
package veri5_eth_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int BYTE_W  = 8;
    localparam int COUNT_W = 16;

endpackage

// File: rtl/veri5_eth_rr_picker.sv
// rtl/veri5_eth_rr_picker.sv - combinational round-robin picker starting after last_id
module veri5_eth_rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      last_id,
    output logic                 pick_vld,
    output logic [ID_W-1:0]      pick_id
);

    // Scan from farthest to nearest so the nearest requester after last_id wins
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(last_id) + i) % NUM_PORTS);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

endmodule

// File: rtl/veri5_eth_pkt_arb.sv
// rtl/veri5_eth_pkt_arb.sv - packet-granular round-robin merge of eth byte streams (option: VERI5_ETH_PKT_ARB_STATS_EN)
module veri5_eth_pkt_arb
    import veri5_eth_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*BYTE_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_sop,
    input  logic [NUM_PORTS-1:0]        in_eop,
    input  logic [NUM_PORTS-1:0]        in_srdy,
    output logic [NUM_PORTS-1:0]        in_drdy,
    output logic [BYTE_W-1:0]           out_data,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        out_srdy,
    input  logic                        out_drdy,
    output logic                        grant_vld,
    output logic [ID_W-1:0]             grant_id,
    output logic                        err_sop
`ifdef VERI5_ETH_PKT_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*COUNT_W-1:0] pkt_cnt
`endif
);

    arb_state_t      state;
    arb_state_t      next_state;
    logic [ID_W-1:0] last_id;
    logic            first_beat;
    logic            pick_vld;
    logic [ID_W-1:0] pick_id;
    logic            xfer;

    veri5_eth_rr_picker #(
        .NUM_PORTS(NUM_PORTS),
        .ID_W     (ID_W)
    ) u_picker (
        .req     (in_srdy & in_sop),
        .last_id (last_id),
        .pick_vld(pick_vld),
        .pick_id (pick_id)
    );

    assign grant_vld = (state == ARB_BUSY);
    assign xfer      = out_srdy && out_drdy;

    // Next state plus the passthrough mux; everything is quiet while idle
    always_comb begin
        next_state = state;
        in_drdy    = '0;
        out_data   = '0;
        out_sop    = 1'b0;
        out_eop    = 1'b0;
        out_srdy   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    next_state = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant_id == ID_W'(i)) begin
                        out_data   = in_data[i*BYTE_W +: BYTE_W];
                        out_sop    = in_sop[i];
                        out_eop    = in_eop[i];
                        out_srdy   = in_srdy[i];
                        in_drdy[i] = out_drdy;
                    end
                end
                if (out_srdy && out_drdy && out_eop) begin
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // Grant bookkeeping: latch the pick, flag stray sops, remember the last winner on eop
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            last_id    <= ID_W'(NUM_PORTS - 1);
            first_beat <= 1'b0;
            err_sop    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && pick_vld) begin
                grant_id   <= pick_id;
                first_beat <= 1'b1;
            end
            if (state == ARB_BUSY && xfer) begin
                first_beat <= 1'b0;
                if (out_sop && !first_beat) begin
                    err_sop <= 1'b1;
                end
                if (out_eop) begin
                    last_id <= grant_id;
                end
            end
        end
    end

`ifdef VERI5_ETH_PKT_ARB_STATS_EN
    logic [COUNT_W-1:0] cnt_q [NUM_PORTS];

    // Count completed packets per port; counters wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (state == ARB_BUSY && xfer && out_eop) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_id == ID_W'(i)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign pkt_cnt[g*COUNT_W +: COUNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_veri5_eth_pkt_arb.sv
// tb/tb_veri5_eth_pkt_arb.sv - self-checking bench for veri5_eth_pkt_arb
module tb_veri5_eth_pkt_arb;

    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP*8-1:0] in_data;
    logic [NP-1:0] in_sop, in_eop, in_srdy, in_drdy;
    logic [7:0]    out_data;
    logic          out_sop, out_eop, out_srdy, out_drdy;
    logic          grant_vld;
    logic [1:0]    grant_id;
    logic          err_sop;
`ifdef VERI5_ETH_PKT_ARB_STATS_EN
    logic [NP*16-1:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    veri5_eth_pkt_arb #(.NUM_PORTS(NP)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_srdy  (in_srdy),
        .in_drdy  (in_drdy),
        .out_data (out_data),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_srdy (out_srdy),
        .out_drdy (out_drdy),
        .grant_vld(grant_vld),
        .grant_id (grant_id),
        .err_sop  (err_sop)
`ifdef VERI5_ETH_PKT_ARB_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    typedef struct packed {logic [7:0] d; logic sop; logic eop;} beat_t;
    typedef struct packed {logic [1:0] id; logic [7:0] d; logic sop; logic eop;} exp_t;
    typedef struct packed {
        logic [3:0]  mask;
        logic [3:0]  npk;
        logic [3:0]  len;
        logic [3:0]  n_order;
        logic [31:0] order;
    } row_t;

    beat_t     src_q[NP][$];
    exp_t      exp_q[$];
    logic [NP-1:0] src_en;
    logic [NP-1:0] fire;
    exp_t      mon_e;
    beat_t     drv_b;
    int        n_tests = 0;
    int        n_fail  = 0;
    int        xfer_cnt = 0;
    row_t      tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_beat(input int p, input logic [7:0] d, input logic sop, input logic eop,
                             input bit to_src, input bit to_exp);
        beat_t b;
        exp_t  e;
        b = '{d: d, sop: sop, eop: eop};
        e = '{id: 2'(p), d: d, sop: sop, eop: eop};
        if (to_src) src_q[p].push_back(b);
        if (to_exp) exp_q.push_back(e);
    endtask

    task automatic push_pkt(input int p, input int len, input logic [7:0] base, input int errbeat,
                            input bit to_src, input bit to_exp);
        for (int b = 0; b < len; b++) begin
            push_beat(p, base + 8'(b), (b == 0) || (b == errbeat), b == len - 1, to_src, to_exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NP; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_xfer(input string name, input int target);
        int n;
        n = 0;
        while (xfer_cnt < target && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(xfer_cnt), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] row_base(input int r, input int p, input int k);
        return {3'(r), 2'(p), 1'(k), 2'b00};
    endfunction

    // Source models and output monitor: sample at negedge, update sources just after posedge
    always begin
        @(negedge clk);
        for (int i = 0; i < NP; i++) fire[i] = !rst && in_srdy[i] && in_drdy[i];
        if (!rst && out_srdy && out_drdy) begin
            xfer_cnt++;
            check("drdy_onehot", 32'(in_drdy), 32'd1 << grant_id);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %0h from port %0d with empty scoreboard",
                         out_data, grant_id);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat", 32'({grant_id, out_data, out_sop, out_eop}), 32'(mon_e));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_en[i] && src_q[i].size() > 0) begin
                drv_b = src_q[i][0];
                in_srdy[i] = 1'b1;
                in_sop[i]  = drv_b.sop;
                in_eop[i]  = drv_b.eop;
                in_data[i*8 +: 8] = drv_b.d;
            end else begin
                in_srdy[i] = 1'b0;
                in_sop[i]  = 1'b0;
                in_eop[i]  = 1'b0;
                in_data[i*8 +: 8] = 8'h00;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt[NP];
        logic [31:0] tmp;
        int p;

        tbl[0] = '{mask: 4'b1111, npk: 4'd2, len: 4'd2, n_order: 4'd8, order: 32'h3210_3210};
        tbl[1] = '{mask: 4'b0110, npk: 4'd1, len: 4'd1, n_order: 4'd2, order: 32'h0000_0021};
        tbl[2] = '{mask: 4'b0011, npk: 4'd1, len: 4'd3, n_order: 4'd2, order: 32'h0000_0010};
        tbl[3] = '{mask: 4'b1001, npk: 4'd1, len: 4'd2, n_order: 4'd2, order: 32'h0000_0003};
        tbl[4] = '{mask: 4'b0101, npk: 4'd1, len: 4'd4, n_order: 4'd2, order: 32'h0000_0002};
        tbl[5] = '{mask: 4'b0001, npk: 4'd1, len: 4'd1, n_order: 4'd1, order: 32'h0000_0000};

        rst = 1'b1;
        in_data = '0; in_sop = '0; in_eop = '0; in_srdy = '0;
        out_drdy = 1'b1;
        src_en = '1;
        do_reset();

        check("rst_grant_vld", 32'(grant_vld), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_err_sop", 32'(err_sop), 0);
        check("rst_out_srdy", 32'(out_srdy), 0);
        check("rst_in_drdy", 32'(in_drdy), 0);
        check("rst_out_data", 32'(out_data), 0);

        // Port 2 sends AA BB CC after reset
        push_beat(2, 8'hAA, 1'b1, 1'b0, 1, 1);
        push_beat(2, 8'hBB, 1'b0, 1'b0, 1, 1);
        push_beat(2, 8'hCC, 1'b0, 1'b1, 1, 1);
        tick();
        check("t1_idle_when_sop", 32'(grant_vld), 0);
        tick();
        check("t1_grant_vld", 32'(grant_vld), 1);
        check("t1_grant_id", 32'(grant_id), 2);
        check("t1_aa", 32'({out_data, out_sop, out_eop}), 32'({8'hAA, 1'b1, 1'b0}));
        tick();
        check("t1_bb", 32'({out_data, out_sop, out_eop}), 32'({8'hBB, 1'b0, 1'b0}));
        tick();
        check("t1_cc", 32'({out_data, out_sop, out_eop}), 32'({8'hCC, 1'b0, 1'b1}));
        tick();
        check("t1_idle_after", 32'({grant_vld, out_srdy}), 0);
        check("t1_drained", 32'(exp_q.size()), 0);

        // Round-robin order table, starting fresh from reset
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NP; i++) begin
                cnt[i] = 0;
                if (tbl[r].mask[i]) begin
                    for (int k = 0; k < int'(tbl[r].npk); k++) begin
                        push_pkt(i, int'(tbl[r].len), row_base(r, i, k), -1, 1, 0);
                    end
                end
            end
            for (int j = 0; j < int'(tbl[r].n_order); j++) begin
                tmp = tbl[r].order >> (4 * j);
                p = int'(tmp[3:0]);
                push_pkt(p, int'(tbl[r].len), row_base(r, p, cnt[p]), -1, 0, 1);
                cnt[p]++;
            end
            drain($sformatf("rr_row%0d", r), 200);
        end

        // Port 1 stalls by downstream and by its own srdy; port 0 waits behind it
        base = xfer_cnt;
        push_pkt(1, 4, 8'h40, -1, 1, 1);
        push_pkt(0, 2, 8'h50, -1, 1, 0);
        push_pkt(0, 2, 8'h50, -1, 0, 1);
        wait_xfer("stall_first_beat", base + 1);
        out_drdy = 1'b1;
        tick();
        out_drdy = 1'b0;
        tick();
        check("stall_hold_grant", 32'({grant_vld, grant_id}), 32'({1'b1, 2'd1}));
        check("stall_no_drdy", 32'(in_drdy), 0);
        tick();
        check("stall_hold_grant2", 32'({grant_vld, grant_id}), 32'({1'b1, 2'd1}));
        out_drdy = 1'b1;
        src_en[1] = 1'b0;
        tick();
        tick();
        tick();
        check("srdy_drop_hold", 32'({grant_vld, grant_id}), 32'({1'b1, 2'd1}));
        src_en[1] = 1'b1;
        drain("stall_drain", 100);

        // Port 3 raises sop again on beat 2
        base = xfer_cnt;
        push_pkt(3, 4, 8'h70, 1, 1, 1);
        wait_xfer("err_first_beat", base + 1);
        check("err_clear_before", 32'(err_sop), 0);
        tick();
        check("err_second_beat", 32'(xfer_cnt), 32'(base + 2));
        check("err_set_next", 32'(err_sop), 1);
        drain("err_drain", 50);
        check("err_sticky", 32'(err_sop), 1);
        push_pkt(0, 2, 8'h80, -1, 1, 1);
        drain("err_clean_pkt", 50);
        check("err_sticky2", 32'(err_sop), 1);

        // Reset while port 0 is on beat 2 of 5
        base = xfer_cnt;
        push_pkt(0, 5, 8'h90, -1, 1, 1);
        wait_xfer("rst_first_beat", base + 1);
        rst = 1'b1;
        tick();
        check("rst_mid_vld", 32'({grant_vld, out_srdy}), 0);
        check("rst_mid_err", 32'(err_sop), 0);
        check("rst_mid_id", 32'(grant_id), 0);
        clear_all();
        rst = 1'b0;
        push_pkt(1, 2, 8'hA0, -1, 1, 0);
        push_pkt(0, 2, 8'hB0, -1, 1, 1);
        push_pkt(1, 2, 8'hA0, -1, 0, 1);
        drain("rst_regrant", 50);

`ifdef VERI5_ETH_PKT_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) push_pkt(1, 1, 8'(8'hC0 + k), -1, 1, 1);
        drain("stats_drain", 50);
        check("stats_p0", 32'(pkt_cnt[15:0]), 0);
        check("stats_p1", 32'(pkt_cnt[31:16]), 3);
        check("stats_p2", 32'(pkt_cnt[47:32]), 0);
        check("stats_p3", 32'(pkt_cnt[63:48]), 0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
